// File: rtl/uart_string_sender_if.sv
// Handshake bundle between the string sender, its BRAM read port, the UART
// transmitter and the commanding host.
interface uart_string_sender_if #(
    parameter int AddrWidth = 19
);
    logic                 start;
    logic [AddrWidth-1:0] base;
    logic                 busy;
    logic                 done;
    logic                 trunc;
    logic [15:0]          count;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           rdata;
    logic [7:0]           tx_data;
    logic                 tx_stb;
    logic                 tx_rdy;

    modport slave (
        input  start, base, rdata, tx_rdy,
        output busy, done, trunc, count, addr, tx_data, tx_stb
    );

    modport master (
        output start, base, rdata, tx_rdy,
        input  busy, done, trunc, count, addr, tx_data, tx_stb
    );
endinterface

// File: rtl/uart_string_sender.sv
// Streams a NUL-terminated string from BRAM to the UART, one byte per
// ready/strobe handshake, stopping at the first 0x00 or after MaxLen bytes.
module uart_string_sender #(
    parameter int AddrWidth = 19,
    parameter int MaxLen    = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uart_string_sender_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, FETCH, CHECK, SEND, STROBE} state_e;

    localparam logic [15:0] MaxCnt = 16'(MaxLen);

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 trunc_q;
    logic                 stb_q;
    logic [15:0]          count_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           tx_data_q;

    logic [15:0]          count_d;
    logic [AddrWidth-1:0] addr_d;

    // Address wraps silently at 2^AddrWidth.
    assign addr_d  = addr_q + 1'b1;
    assign count_d = count_q + 16'd1;

    // Every output leaves through a register; nothing combinational from
    // RDATA or TX_RDY reaches a port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            trunc_q   <= 1'b0;
            stb_q     <= 1'b0;
            count_q   <= 16'd0;
            addr_q    <= '0;
            tx_data_q <= 8'hFF;
        end else begin
            done_q <= 1'b0;
            stb_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q  <= bus.base;
                        count_q <= 16'd0;
                        trunc_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: state_q <= CHECK;
                CHECK: begin
                    if (bus.rdata == 8'h00) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (count_q == MaxCnt) begin
                        // Limit reached with string still going: drop this byte.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        trunc_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tx_data_q <= bus.rdata;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_rdy) begin
                        stb_q   <= 1'b1;
                        state_q <= STROBE;
                    end
                end
                STROBE: begin
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.trunc   = trunc_q;
    assign bus.count   = count_q;
    assign bus.addr    = addr_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_stb  = stb_q;
endmodule

// File: doc/uart_string_sender.md
# uart_string_sender

Command-driven sequencer that streams a NUL-terminated byte string from block RAM into the UART transmitter. A host pulses START with a base address. The block fetches bytes one at a time, hands each to the UART under a ready/strobe handshake, and stops at the first 0x00 or at a length limit. It replaces free-running address stepping between the BRAM read port and the UART data input.

## Interface
- AddrWidth, 19, width of the BRAM byte address
- MaxLen, 256, maximum bytes sent per command (1..65535)
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  command strobe; sampled only in IDLE
- BASE  in  AddrWidth  string start address, captured with START
- BUSY  out  1  high whenever state is not IDLE
- DONE  out  1  one-cycle pulse when a command completes
- TRUNC  out  1  set at completion if MaxLen was reached before a NUL; held until next accepted START
- COUNT  out  16  bytes sent by the current or last command
- ADDR  out  AddrWidth  BRAM read address (registered)
- RDATA  in  8  BRAM read data, valid one cycle after ADDR changes
- TX_DATA  out  8  byte offered to UART (registered)
- TX_STB  out  1  one-cycle transmit strobe
- TX_RDY  in  1  UART can accept a byte

## Operation
- States: IDLE, FETCH, CHECK, SEND, STROBE.
- IDLE: on START=1, ADDR<=BASE, COUNT<=0, TRUNC<=0, go to FETCH. START in any other state is ignored; no queueing.
- FETCH: single wait cycle for BRAM latency, then go to CHECK.
- CHECK: RDATA is valid here.
  - RDATA==0: go to IDLE and pulse DONE.
  - Else if COUNT==MaxLen: go to IDLE, set TRUNC=1 and pulse DONE. The fetched byte is not sent.
  - Else: TX_DATA<=RDATA and go to SEND.
- SEND: hold TX_DATA. If TX_RDY=1, go to STROBE; otherwise stay in SEND indefinitely.
- STROBE: TX_STB=1 for this cycle only. ADDR<=ADDR+1 (modulo 2^AddrWidth, wraps silently), COUNT<=COUNT+1, go to FETCH.
- Outputs are Moore-decoded from state or registered; no combinational path from TX_RDY or RDATA to any output.
- The UART must drop TX_RDY within 2 cycles after a TX_STB cycle. The next SEND is reached no earlier than 3 cycles after STROBE.
- Reset values (asserted asynchronously, regardless of state):
  - state=IDLE, BUSY=0, DONE=0, TRUNC=0, TX_STB=0
  - COUNT=0, ADDR=0, TX_DATA=0xFF
- Reset mid-command abandons the command. No DONE is generated and no partial strobe is emitted.

## Timing
- Cycle 0: START sampled in IDLE. Cycle 1: FETCH, ADDR=BASE. Cycle 2: CHECK.
- With TX_RDY held high: cycle 3 SEND, cycle 4 STROBE (first TX_STB).
- Steady-state throughput is 1 byte per 4 cycles when TX_RDY is already high.
- Empty string: DONE high in cycle 3 (the first IDLE cycle), COUNT=0, no TX_STB.
- DONE is high in the first IDLE cycle after completion. BUSY is low in that same cycle.
- A START in that same cycle is accepted.
- TX_DATA changes only on the CHECK→SEND transition. It is stable from SEND through STROBE.
- COUNT updates the cycle after STROBE. The final value holds until the next accepted START.

## Test plan
- BRAM[0x10..0x12]="Hi\0", TX_RDY=1, START with BASE=0x10 -> two TX_STB pulses, 4 cycles apart, TX_DATA 0x48 then 0x69; DONE in cycle 11; COUNT=2; TRUNC=0.
- BRAM[0x20]=0x00, START BASE=0x20 -> no TX_STB; DONE in cycle 3; COUNT=0; BUSY high for cycles 1–2 only.
- "A\0" with TX_RDY low for 100 cycles after CHECK -> state stays SEND, TX_DATA=0x41 stable, no TX_STB. TX_RDY high -> exactly one TX_STB on the next cycle.
- MaxLen=4, BRAM holds 6 nonzero bytes then 0 -> exactly 4 strobes; DONE; TRUNC=1; COUNT=4. The next START clears TRUNC.
- BASE=0x7FFFF, BRAM[0x7FFFF]=0x41, BRAM[0]=0x42, BRAM[1]=0 -> ADDR wraps to 0; bytes 0x41, 0x42 sent; COUNT=2.
- Second START while BUSY -> ignored and BASE not recaptured. RST pulse during SEND -> BUSY=0 and TX_STB=0 immediately, all outputs at reset values, no DONE; a new START then runs normally.
